multi_axis_stepper: RTL
=======================

// Module: multi_axis_stepper
// PURPOSE
//  Parametrised N-axis step/direction pulse generator, successor to the two-axis stepper_controller.
//  Accepts one coordinated move command: per-axis step period, step count and direction.
//  Emits bounded step trains, with busy/done handshake back to the processor-side register glue.
//  Sits between the regfile-mapped command registers and the motor driver pins.
// PARAMETERS
//  NUM_AXES  2   number of independent axes
//  PERIOD_W  32  width of per-axis step period (clk cycles per step)
//  COUNT_W   16  width of per-axis step count
// PORTS
//  clk        in   1                  master clock, all logic on rising edge
//  reset      in   1                  synchronous, active-high
//  cmd_valid  in   1                  move command present
//  cmd_ready  out  1                  = ~busy (combinational)
//  cmd_period in   NUM_AXES*PERIOD_W  axis i at [i*PERIOD_W +: PERIOD_W]
//  cmd_steps  in   NUM_AXES*COUNT_W   axis i at [i*COUNT_W +: COUNT_W]
//  cmd_dir    in   NUM_AXES           direction per axis
//  abort      in   1                  stop all axes
//  step       out  NUM_AXES           step pulse train per axis
//  dir        out  NUM_AXES           latched direction per axis
//  busy       out  1                  move in progress
//  done       out  1                  one-cycle pulse at move end
//  error      out  1                  sticky: illegal period in last command
// BEHAVIOUR
//  Reset: step=0, dir=0, busy=0, done=0, error=0, all counters 0; axis FSMs to IDLE. Mid-move reset kills the move, no done pulse.
//  Accept: cmd_valid && cmd_ready at edge k. Period, steps and dir latched; dir updates at k; error cleared at k.
//  Legality: an axis with steps!=0 and period<2 is illegal.
//    - Any illegal axis: whole command consumes no motion; error=1; done pulses at k+1; busy stays 0.
//  Per-axis FSM states:
//    IDLE -> RUN on a legal accept with steps!=0; steps==0 axes stay IDLE (already finished).
//    RUN: phase counter p runs 0..period-1, starting at p=0 in the cycle after accept.
//      step=1 while p < period>>1, else 0 (period=3 -> 1 high, 2 low).
//      At p==period-1: remaining steps decrement; at remaining==0 -> DONE, else p wraps to 0.
//    DONE: step=0, waits for the move to end.
//  Move end: all axes IDLE/DONE. busy falls and done=1 in the following single cycle; axes -> IDLE.
//    - All-zero steps command: done at k+1, busy never rises.
//  busy=1 from cycle k+1 to move end; cmd_valid while busy is ignored (not queued).
//  abort (busy=1): at next edge all step=0, axes -> IDLE, busy=0, done=1; dir and error held.
//    - abort while idle: ignored. abort together with accept: abort wins, command dropped, done not pulsed.
//  Arithmetic unsigned; counters exactly PERIOD_W/COUNT_W wide, never wrap (bounded by latched values).
// CONFIGURATION
//  STEPPER_POSITION_EN defined:
//    - Adds output position [NUM_AXES*COUNT_W+NUM_AXES-1:0], signed (COUNT_W+1) bits per axis, reset 0.
//    - Per completed step: +1 if dir=1, -1 if dir=0; two's-complement wrap; an aborted partial step is not counted.
//  Not defined: port and counters absent; no other difference.
// STRUCTURE
//  Package plotter_pkg: axis_state_t enum {IDLE,RUN,DONE}; localparam MIN_PERIOD=2.
//  Sub-module stepper_axis: one per axis, via generate loop; holds period/step counters and FSM.
//  Top holds the handshake, legality check, done/busy/error and any abort logic.
// TESTING
//  1) Period=4, steps=3, NUM_AXES=2 with axis1 steps=0:
//     - step0 is 1,1,0,0 x3 starting cycle k+1; done at k+13; busy k+1..k+12.
//  2) Axis0 (p=4,n=2) and axis1 (p=6,n=1):
//     - axis1 DONE at k+6, step1 stays 0 after; done only after axis0 finishes (k+9).
//  3) Period=1, steps=5 on axis0:
//     - no step edges; error=1 from k+1; done pulse k+1; next legal accept clears error.
//  4) abort asserted mid-high-phase of step0:
//     - step0=0 next cycle, done pulse, busy=0; with POSITION_EN only completed steps counted.
//  5) reset asserted mid-move:
//     - all outputs 0 next cycle, no done; cmd_valid while busy is never accepted (cmd_ready=0).

Source files
------------

// File: rtl/plotter_pkg.sv
// Shared types and constants for the multi-axis step/direction generator.
package plotter_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} axis_state_t;
  localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/multi_axis_stepper_if.sv
// Command/status bundle between register glue and the stepper.
// Optional STEPPER_POSITION_EN adds the per-axis position readback.
interface multi_axis_stepper_if #(
  parameter int NUM_AXES = 2,
  parameter int PERIOD_W = 32,
  parameter int COUNT_W  = 16
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [NUM_AXES*PERIOD_W-1:0] cmd_period;
  logic [NUM_AXES*COUNT_W-1:0]  cmd_steps;
  logic [NUM_AXES-1:0]          cmd_dir;
  logic                         abort;
  logic [NUM_AXES-1:0]          step;
  logic [NUM_AXES-1:0]          dir;
  logic                         busy;
  logic                         done;
  logic                         error;
`ifdef STEPPER_POSITION_EN
  logic [NUM_AXES*COUNT_W+NUM_AXES-1:0] position;
`endif

  modport master (
    output cmd_valid, cmd_period, cmd_steps, cmd_dir, abort,
    input  cmd_ready, step, dir, busy, done, error
`ifdef STEPPER_POSITION_EN
    , input position
`endif
  );

  modport slave (
    input  cmd_valid, cmd_period, cmd_steps, cmd_dir, abort,
    output cmd_ready, step, dir, busy, done, error
`ifdef STEPPER_POSITION_EN
    , output position
`endif
  );
endinterface

// File: rtl/stepper_axis.sv
// One axis: phase counter, remaining-step counter and IDLE/RUN/DONE FSM.
// STEPPER_POSITION_EN adds a signed step-position accumulator.
module stepper_axis
  import plotter_pkg::*;
#(
  parameter int PERIOD_W = 32,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_clear,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic [COUNT_W-1:0]  i_steps,
`ifdef STEPPER_POSITION_EN
  input  logic                i_abort,
  input  logic                i_dir,
  output logic [COUNT_W:0]    o_pos,
`endif
  output logic                o_step,
  output logic                o_last,
  output axis_state_t         o_state
);
  axis_state_t         r_state;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_p;
  logic [COUNT_W-1:0]  r_rem;
  logic                w_wrap;

  assign w_wrap  = (r_state == RUN) && (r_p == r_period - PERIOD_W'(1));
  assign o_last  = w_wrap && (r_rem == COUNT_W'(1));
  assign o_step  = (r_state == RUN) && (r_p < (r_period >> 1));
  assign o_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_period <= '0;
      r_p      <= '0;
      r_rem    <= '0;
    end else if (i_clear) begin
      r_state <= IDLE;
      r_p     <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_state  <= RUN;
          r_period <= i_period;
          r_p      <= '0;
          r_rem    <= i_steps;
        end
        RUN: if (w_wrap) begin
          r_p   <= '0;
          r_rem <= r_rem - COUNT_W'(1);
          if (r_rem == COUNT_W'(1)) r_state <= DONE;
        end else begin
          r_p <= r_p + PERIOD_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef STEPPER_POSITION_EN
  // The final step of a move completes on the same edge as the move-end clear, so only abort suppresses counting.
  logic [COUNT_W:0] r_pos;
  assign o_pos = r_pos;
  always_ff @(posedge clk) begin
    if (reset)
      r_pos <= '0;
    else if (w_wrap && !i_abort)
      r_pos <= i_dir ? r_pos + 1'b1 : r_pos - 1'b1;
  end
`endif
endmodule

// File: rtl/multi_axis_stepper.sv
// N-axis step/direction generator: command handshake, legality check, busy/done/error.
// Build with STEPPER_POSITION_EN for per-axis position tracking.
module multi_axis_stepper
  import plotter_pkg::*;
#(
  parameter int NUM_AXES = 2,
  parameter int PERIOD_W = 32,
  parameter int COUNT_W  = 16
) (
  input logic                clk,
  input logic                reset,
  multi_axis_stepper_if.slave bus
);
  logic                r_busy, r_done, r_error;
  logic [NUM_AXES-1:0] r_dir;
  logic [NUM_AXES-1:0] w_step, w_last, w_fin, w_nz, w_ill;
  logic                w_accept, w_go, w_abort, w_end, w_clear;
`ifdef STEPPER_POSITION_EN
  logic [NUM_AXES-1:0][COUNT_W:0] w_pos;
  assign bus.position = w_pos;
`endif

  assign w_accept = bus.cmd_valid && !r_busy && !bus.abort;
  assign w_go     = w_accept && !(|w_ill) && (|w_nz);
  assign w_abort  = bus.abort && r_busy;
  assign w_end    = r_busy && (&w_fin);
  assign w_clear  = w_abort || w_end;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_AXES; gi++) begin : g_axis
      axis_state_t w_state;
      assign w_nz[gi]  = |bus.cmd_steps[gi*COUNT_W +: COUNT_W];
      assign w_ill[gi] = w_nz[gi] &&
                         (bus.cmd_period[gi*PERIOD_W +: PERIOD_W] < PERIOD_W'(MIN_PERIOD));
      // An axis counts as finished if it is not running or completes its last step this cycle.
      assign w_fin[gi] = (w_state != RUN) || w_last[gi];

      stepper_axis #(.PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W)) u_axis (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_go && w_nz[gi]),
        .i_clear  (w_clear),
        .i_period (bus.cmd_period[gi*PERIOD_W +: PERIOD_W]),
        .i_steps  (bus.cmd_steps[gi*COUNT_W +: COUNT_W]),
`ifdef STEPPER_POSITION_EN
        .i_abort  (w_abort),
        .i_dir    (r_dir[gi]),
        .o_pos    (w_pos[gi]),
`endif
        .o_step   (w_step[gi]),
        .o_last   (w_last[gi]),
        .o_state  (w_state)
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_dir   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_dir   <= bus.cmd_dir;
        r_error <= |w_ill;
        if (w_go) r_busy <= 1'b1;
        else      r_done <= 1'b1;
      end else if (w_clear) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready = !r_busy;
  assign bus.step      = w_step;
  assign bus.dir       = r_dir;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_error;
endmodule
